// File: rtl/alu_branch_unit.sv
// Execute stage for KGP-RISC: ALU control decode, ALU, carry flag and next-PC resolution.
// Optional `ALU_DIFF_EN` enables the signed absolute-difference op (func 001010, control 1011).
module alu_branch_unit #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             branch,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] dest_addr,
    output logic [3:0]       alu_control_signal,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flags,
    output logic [WIDTH-1:0] pc_out,
    output logic             taken,
    output logic             link_we,
    output logic [WIDTH-1:0] link_addr
);

    localparam logic [3:0] CTL_ADD   = 4'b0000;
    localparam logic [3:0] CTL_COMP  = 4'b0001;
    localparam logic [3:0] CTL_AND   = 4'b0010;
    localparam logic [3:0] CTL_XOR   = 4'b0011;
    localparam logic [3:0] CTL_SHLL  = 4'b0100;
    localparam logic [3:0] CTL_SHRL  = 4'b0101;
    localparam logic [3:0] CTL_SHLLV = 4'b0110;
    localparam logic [3:0] CTL_SHRLV = 4'b0111;
    localparam logic [3:0] CTL_SHRA  = 4'b1000;
    localparam logic [3:0] CTL_SHRAV = 4'b1001;
    localparam logic [3:0] CTL_PASS  = 4'b1010;
    localparam logic [3:0] CTL_DIFF  = 4'b1011;
    localparam logic [3:0] CTL_NOP   = 4'b1111;

    localparam logic [5:0] BR_B    = 6'b000000;
    localparam logic [5:0] BR_BR   = 6'b000001;
    localparam logic [5:0] BR_BLTZ = 6'b000010;
    localparam logic [5:0] BR_BZ   = 6'b000011;
    localparam logic [5:0] BR_BNZ  = 6'b000100;
    localparam logic [5:0] BR_BL   = 6'b000101;
    localparam logic [5:0] BR_BCY  = 6'b000110;
    localparam logic [5:0] BR_BNCY = 6'b000111;

    logic [3:0]       ctl;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] pc_plus4;
    logic             carry_q;
    logic             carry_d;

    always_comb begin
        ctl = CTL_NOP;
        unique case (alu_op)
            3'b000: begin
                unique case (func_code)
                    6'b000000: ctl = CTL_ADD;
                    6'b000001: ctl = CTL_COMP;
                    6'b000010: ctl = CTL_AND;
                    6'b000011: ctl = CTL_XOR;
                    6'b000100: ctl = CTL_SHLL;
                    6'b000101: ctl = CTL_SHRL;
                    6'b000110: ctl = CTL_SHLLV;
                    6'b000111: ctl = CTL_SHRLV;
                    6'b001000: ctl = CTL_SHRA;
                    6'b001001: ctl = CTL_SHRAV;
`ifdef ALU_DIFF_EN
                    6'b001010: ctl = CTL_DIFF;
`endif
                    default:   ctl = CTL_NOP;
                endcase
            end
            3'b001:  ctl = CTL_ADD;
            3'b010:  ctl = CTL_COMP;
            3'b011:  ctl = CTL_ADD;
            3'b100:  ctl = CTL_PASS;
            default: ctl = CTL_NOP;
        endcase
    end

    assign sum = {1'b0, input1} + {1'b0, input2};

`ifdef ALU_DIFF_EN
    // One extra bit keeps the signed difference exact; |diff| < 2^WIDTH so the low bits suffice.
    logic signed [WIDTH:0] diff_raw;
    logic [WIDTH-1:0]      diff_abs;
    assign diff_raw = $signed({input1[WIDTH-1], input1}) - $signed({input2[WIDTH-1], input2});
    assign diff_abs = diff_raw[WIDTH] ? (~diff_raw[WIDTH-1:0] + 1'b1) : diff_raw[WIDTH-1:0];
`endif

    always_comb begin
        result = '0;
        unique case (ctl)
            CTL_ADD:   result = sum[WIDTH-1:0];
            CTL_COMP:  result = ~input2 + 1'b1;
            CTL_AND:   result = input1 & input2;
            CTL_XOR:   result = input1 ^ input2;
            CTL_SHLL:  result = input1 << shamt;
            CTL_SHRL:  result = input1 >> shamt;
            CTL_SHLLV: result = input1 << input2[4:0];
            CTL_SHRLV: result = input1 >> input2[4:0];
            CTL_SHRA:  result = $unsigned($signed(input1) >>> shamt);
            CTL_SHRAV: result = $unsigned($signed(input1) >>> input2[4:0]);
            CTL_PASS:  result = input1;
`ifdef ALU_DIFF_EN
            CTL_DIFF:  result = diff_abs;
`endif
            default:   result = '0;
        endcase
    end

    assign alu_control_signal = ctl;
    assign out                = result;
    assign flags              = {carry_q, (result == '0), result[WIDTH-1]};

    // Only add-class operations update the architectural carry.
    always_comb begin
        carry_d = carry_q;
        if (ctl == CTL_ADD) begin
            carry_d = sum[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign pc_plus4  = pc_in + WIDTH'(4);
    assign link_addr = pc_plus4;

    always_comb begin
        pc_out  = pc_plus4;
        taken   = 1'b0;
        link_we = 1'b0;
        if (rst) begin
            pc_out = RESET_PC;
        end else if (branch) begin
            unique case (func_code)
                BR_B:    begin taken = 1'b1; pc_out = dest_addr; end
                BR_BR:   begin taken = 1'b1; pc_out = input1; end
                BR_BLTZ: taken = input1[WIDTH-1];
                BR_BZ:   taken = (input1 == '0);
                BR_BNZ:  taken = (input1 != '0);
                BR_BL:   begin taken = 1'b1; pc_out = dest_addr; link_we = 1'b1; end
                BR_BCY:  taken = carry_q;
                BR_BNCY: taken = ~carry_q;
                default: taken = 1'b0;
            endcase
            if (taken && (func_code inside {BR_BLTZ, BR_BZ, BR_BNZ, BR_BCY, BR_BNCY})) begin
                pc_out = dest_addr;
            end
        end
    end

endmodule

// File: tb/tb_alu_branch_unit.sv
// Randomized bench for alu_branch_unit against a behavioural model, plus literal directed checks.
module tb_alu_branch_unit;

`ifdef ALU_DIFF_EN
    localparam bit DIFF_EN = 1'b1;
`else
    localparam bit DIFF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_op;
    logic [5:0]  func_code;
    logic [4:0]  shamt;
    logic [31:0] input1, input2, pc_in, dest_addr;
    logic        branch;
    logic [3:0]  alu_control_signal;
    logic [31:0] out, pc_out, link_addr;
    logic [2:0]  flags;
    logic        taken, link_we;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit carry_m = 1'b0;

    always #5 clk = ~clk;

    alu_branch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .func_code(func_code), .shamt(shamt),
        .input1(input1), .input2(input2), .branch(branch), .pc_in(pc_in),
        .dest_addr(dest_addr), .alu_control_signal(alu_control_signal), .out(out),
        .flags(flags), .pc_out(pc_out), .taken(taken), .link_we(link_we),
        .link_addr(link_addr)
    );

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] res;
        logic        cy_raw;
        logic [31:0] pc;
        logic        tk;
        logic        lwe;
    } exp_t;

    function automatic exp_t model(input logic r, input logic [2:0] op, input logic [5:0] fc,
                                   input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                                   input logic br, input logic [31:0] pc, input logic [31:0] dst,
                                   input logic cy);
        exp_t e;
        longint unsigned s;
        longint d;
        logic [31:0] tgt;
        s = longint'(a) + longint'(b);
        e.cy_raw = s[32];
        case (op)
            3'd0:    e.ctl = (fc <= 6'd9) ? fc[3:0] : ((fc == 6'd10 && DIFF_EN) ? 4'd11 : 4'd15);
            3'd1, 3'd3: e.ctl = 4'd0;
            3'd2:    e.ctl = 4'd1;
            3'd4:    e.ctl = 4'd10;
            default: e.ctl = 4'd15;
        endcase
        case (e.ctl)
            4'd0:  e.res = s[31:0];
            4'd1:  e.res = 32'd0 - b;
            4'd2:  e.res = a & b;
            4'd3:  e.res = a ^ b;
            4'd4:  e.res = a << sh;
            4'd5:  e.res = a >> sh;
            4'd6:  e.res = a << b[4:0];
            4'd7:  e.res = a >> b[4:0];
            4'd8:  e.res = $unsigned($signed(a) >>> sh);
            4'd9:  e.res = $unsigned($signed(a) >>> b[4:0]);
            4'd10: e.res = a;
            4'd11: begin
                d = longint'($signed(a)) - longint'($signed(b));
                if (d < 0) d = -d;
                e.res = d[31:0];
            end
            default: e.res = 32'd0;
        endcase
        e.tk = 1'b0; e.lwe = 1'b0; tgt = dst;
        if (br) begin
            case (fc)
                6'd0: e.tk = 1'b1;
                6'd1: begin e.tk = 1'b1; tgt = a; end
                6'd2: e.tk = a[31];
                6'd3: e.tk = (a == 0);
                6'd4: e.tk = (a != 0);
                6'd5: begin e.tk = 1'b1; e.lwe = 1'b1; end
                6'd6: e.tk = cy;
                6'd7: e.tk = !cy;
                default: e.tk = 1'b0;
            endcase
        end
        e.pc = e.tk ? tgt : pc + 32'd4;
        if (r) begin e.pc = 32'd0; e.tk = 1'b0; e.lwe = 1'b0; end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference carry, updated on the same edge as the DUT.
    always @(posedge clk) begin
        exp_t e;
        e = model(rst, alu_op, func_code, shamt, input1, input2, branch, pc_in, dest_addr, carry_m);
        if (rst) carry_m = 1'b0;
        else if (e.ctl == 4'd0) carry_m = e.cy_raw;
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = model(rst, alu_op, func_code, shamt, input1, input2, branch, pc_in, dest_addr, carry_m);
            chk("ctl",       {28'd0, alu_control_signal}, {28'd0, e.ctl});
            chk("out",       out, e.res);
            chk("flags",     {29'd0, flags}, {29'd0, carry_m, (e.res == 32'd0), e.res[31]});
            chk("pc_out",    pc_out, e.pc);
            chk("taken",     {31'd0, taken}, {31'd0, e.tk});
            chk("link_we",   {31'd0, link_we}, {31'd0, e.lwe});
            chk("link_addr", link_addr, pc_in + 32'd4);
        end
    end

    task automatic drive(input logic r, input logic [2:0] op, input logic [5:0] fc, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input logic br,
                         input logic [31:0] pc, input logic [31:0] dst);
        rst = r; alu_op = op; func_code = fc; shamt = sh; input1 = a; input2 = b;
        branch = br; pc_in = pc; dest_addr = dst;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        drive(1'b1, 3'd0, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        // add overflow: out 0, zero 1, carry set after edge, then bcy taken
        drive(1'b0, 3'd0, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        chk("lit_add_out", out, 32'd0);
        chk("lit_add_zero", {31'd0, flags[1]}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 3'd4, 6'd6, 5'd0, 32'd0, 32'd0, 1'b1, 32'h8, 32'h40);
        @(negedge clk);
        chk("lit_carry_set", {31'd0, flags[2]}, 32'd1);
        chk("lit_bcy_pc", pc_out, 32'h40);
        chk("lit_bcy_taken", {31'd0, taken}, 32'd1);

        @(posedge clk); #1;
        drive(1'b0, 3'd0, 6'd9, 5'd0, 32'h8000_0000, 32'd4, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_shrav_out", out, 32'hF800_0000);
        chk("lit_shrav_sign", {31'd0, flags[0]}, 32'd1);
        chk("lit_shrav_carry", {31'd0, flags[2]}, 32'd1);

        @(posedge clk); #1;
        drive(1'b0, 3'd2, 6'd0, 5'd0, 32'd0, 32'd5, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_comp", out, 32'hFFFF_FFFB);

        @(posedge clk); #1;
        drive(1'b0, 3'd4, 6'd2, 5'd0, 32'hFFFF_FFFD, 32'd0, 1'b1, 32'h100, 32'h20);
        @(negedge clk);
        chk("lit_bltz_neg", pc_out, 32'h20);
        @(posedge clk); #1;
        drive(1'b0, 3'd4, 6'd2, 5'd0, 32'd3, 32'd0, 1'b1, 32'h100, 32'h20);
        @(negedge clk);
        chk("lit_bltz_pos_pc", pc_out, 32'h104);
        chk("lit_bltz_pos_taken", {31'd0, taken}, 32'd0);

        @(posedge clk); #1;
        drive(1'b0, 3'd4, 6'd5, 5'd0, 32'd0, 32'd0, 1'b1, 32'h10, 32'h80);
        @(negedge clk);
        chk("lit_bl_pc", pc_out, 32'h80);
        chk("lit_bl_we", {31'd0, link_we}, 32'd1);
        chk("lit_bl_addr", link_addr, 32'h14);
        @(posedge clk); #1;
        drive(1'b1, 3'd4, 6'd5, 5'd0, 32'd0, 32'd0, 1'b1, 32'h10, 32'h80);
        @(negedge clk);
        chk("lit_rst_pc", pc_out, 32'h0);
        chk("lit_rst_we", {31'd0, link_we}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 3'd5, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'h10, 32'h80);
        @(negedge clk);
        chk("lit_rst_carry", {31'd0, flags[2]}, 32'd0);

        @(posedge clk); #1;
        drive(1'b0, 3'd0, 6'd10, 5'd0, 32'd3, 32'd10, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lit_diff", out, DIFF_EN ? 32'd7 : 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] fc;
            logic [2:0] op;
            @(posedge clk); #1;
            fc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 11));
            op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
            drive(($urandom_range(0, 49) == 0), op, fc, 5'($urandom), rnd_val(), rnd_val(),
                  ($urandom_range(0, 2) == 0), $urandom, $urandom);
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
